trace_checker: RTL and testbench

Synthesizable lock-step checker for the single-cycle CPU. It consumes a golden architectural trace word by word over a valid/ready stream and compares it with the live CPU state after each retired instruction. Each record is pc, instr, then reg0..reg31, in that order. The block stalls the CPU while a record is being compared, and latches the first mismatch for inspection. It sits beside the CPU in sccomp_dataflow and reads the register file through a spare read port.

---
 rtl/trace_checker.sv | 76 +++++++
 tb/tb_trace_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker: lock-step comparison of a golden architectural trace against live CPU state
module trace_checker #(
  parameter int NUM_REGS = 32,
  parameter bit STOP_ON_ERR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_valid,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_instr,
  output logic [4:0]  reg_raddr,
  input  logic [31:0] reg_rdata,
  input  logic        gold_valid,
  input  logic [31:0] gold_data,
  output logic        gold_ready,
  output logic        cpu_stall,
  output logic        mismatch,
  output logic [31:0] err_step,
  output logic [5:0]  err_index,
  output logic [31:0] err_expected,
  output logic [31:0] err_actual,
  output logic [31:0] step_count,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;
  state_t state, state_n;
  logic [5:0] index;
  logic [31:0] pc_snap, instr_snap, actual;
  logic xfer, fail, last, halt_now;
  assign gold_ready = state == CHECK;
  assign cpu_stall = state != IDLE;
  // Register words follow pc and instr, so the read port lags index by two.
  assign reg_raddr = index >= 6'd2 ? 5'(index - 6'd2) : 5'd0;
  assign actual = index == 6'd0 ? pc_snap : index == 6'd1 ? instr_snap : reg_rdata;
  assign xfer = gold_ready && gold_valid;
  assign fail = xfer && gold_data != actual;
  assign last = index == 6'(NUM_REGS + 1);
  assign halt_now = fail && STOP_ON_ERR;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = step_valid ? CHECK : IDLE;
    else if (state == CHECK) state_n = halt_now ? HALT : (xfer && last) ? IDLE : CHECK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      pc_snap <= '0;
      instr_snap <= '0;
      mismatch <= 1'b0;
      err_step <= '0;
      err_index <= '0;
      err_expected <= '0;
      err_actual <= '0;
      step_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && step_valid) begin
        pc_snap <= cpu_pc;
        instr_snap <= cpu_instr;
        index <= '0;
      end
      if (xfer) index <= last ? 6'd0 : index + 6'd1;
      if (fail && !mismatch) begin
        mismatch <= 1'b1;
        err_step <= step_count;
        err_index <= index;
        err_expected <= gold_data;
        err_actual <= actual;
      end
      if (xfer && last && !halt_now) step_count <= step_count + 32'd1;
      if (step_valid && state != IDLE) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: scoreboard bench driving two checkers (halting and logging variants)
module tb_trace_checker;
  logic clk = 1'b0, rst = 1'b1, step_valid = 1'b0, gold_valid = 1'b0, sel = 1'b0;
  logic [31:0] cpu_pc = '0, cpu_instr = '0, gold_data = '0;
  logic [31:0] cpu_regs [32];
  logic [31:0] gw [34];
  logic [4:0] raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b, estep_a, estep_b, eexp_a, eexp_b, eact_a, eact_b, steps_a, steps_b;
  logic [5:0] eidx_a, eidx_b;
  logic ready_a, ready_b, stall_a, stall_b, mis_a, mis_b, perr_a, perr_b;
  logic rdy, stall, mis, perr;
  logic [31:0] steps, estep, eexp, eact;
  logic [5:0] eidx;
  int total = 0, bad = 0;
  typedef struct {
    int cycles; logic stall; logic [31:0] steps; logic mis;
    logic [31:0] estep; logic [5:0] eidx; logic [31:0] eexp; logic [31:0] eact;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_steps, m_estep, m_eexp, m_eact;
  logic [5:0] m_eidx;
  logic m_mis;

  always #5 clk = ~clk;
  assign rdata_a = cpu_regs[raddr_a];
  assign rdata_b = cpu_regs[raddr_b];
  assign rdy = sel ? ready_b : ready_a;
  assign stall = sel ? stall_b : stall_a;
  assign mis = sel ? mis_b : mis_a;
  assign perr = sel ? perr_b : perr_a;
  assign steps = sel ? steps_b : steps_a;
  assign estep = sel ? estep_b : estep_a;
  assign eidx = sel ? eidx_b : eidx_a;
  assign eexp = sel ? eexp_b : eexp_a;
  assign eact = sel ? eact_b : eact_a;

  trace_checker #(.NUM_REGS(32), .STOP_ON_ERR(1)) dut_a (
    .clk(clk), .rst(rst), .step_valid(step_valid), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .reg_raddr(raddr_a), .reg_rdata(rdata_a), .gold_valid(gold_valid), .gold_data(gold_data),
    .gold_ready(ready_a), .cpu_stall(stall_a), .mismatch(mis_a), .err_step(estep_a),
    .err_index(eidx_a), .err_expected(eexp_a), .err_actual(eact_a), .step_count(steps_a),
    .proto_err(perr_a));
  trace_checker #(.NUM_REGS(32), .STOP_ON_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .step_valid(step_valid), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .reg_raddr(raddr_b), .reg_rdata(rdata_b), .gold_valid(gold_valid), .gold_data(gold_data),
    .gold_ready(ready_b), .cpu_stall(stall_b), .mismatch(mis_b), .err_step(estep_b),
    .err_index(eidx_b), .err_expected(eexp_b), .err_actual(eact_b), .step_count(steps_b),
    .proto_err(perr_b));

  task automatic model_reset();
    m_steps = '0; m_mis = 1'b0; m_estep = '0; m_eidx = '0; m_eexp = '0; m_eact = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; step_valid = 1'b0; gold_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic build_gold();
    gw[0] = cpu_pc;
    gw[1] = cpu_instr;
    for (int r = 0; r < 32; r++) gw[r + 2] = cpu_regs[r];
  endtask

  task automatic rand_state(input logic [31:0] pc);
    cpu_pc = pc;
    cpu_instr = $urandom;
    cpu_regs[0] = '0;
    for (int r = 1; r < 32; r++) cpu_regs[r] = $urandom;
  endtask

  // Predicts the record outcome, drives step_valid plus the golden words, then checks the popped prediction.
  task automatic run_record(input bit bub, input int pulse_at, input int abort_at);
    exp_t e;
    bit halt = 1'b0, on = 1'b1, pulsed = 1'b0, xfer, rd;
    int nw = 34, i = 0, n = 0, it = 0;
    logic [31:0] act;
    for (int k = 0; k < 34; k++) begin
      act = k == 0 ? cpu_pc : k == 1 ? cpu_instr : cpu_regs[k - 2];
      if (gw[k] !== act) begin
        if (!m_mis) begin
          m_mis = 1'b1; m_estep = m_steps; m_eidx = 6'(k); m_eexp = gw[k]; m_eact = act;
        end
        if (!sel) begin halt = 1'b1; nw = k + 1; break; end
      end
    end
    if (!halt) m_steps = m_steps + 32'd1;
    e.cycles = (bub ? 2 * nw - 1 : nw) + (halt ? 1 : 0);
    e.stall = halt; e.steps = m_steps; e.mis = m_mis;
    e.estep = m_estep; e.eidx = m_eidx; e.eexp = m_eexp; e.eact = m_eact;
    sb.push_back(e);
    step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    while (i < 34 && it < 400) begin
      gold_valid = bub ? on : 1'b1;
      gold_data = gw[i];
      step_valid = (i == pulse_at) && !pulsed;
      if (i == abort_at) rst = 1'b1;
      @(negedge clk);
      if (stall) n++;
      xfer = gold_valid && rdy;
      rd = rdy;
      @(posedge clk);
      #1;
      pulsed |= step_valid;
      step_valid = 1'b0;
      on = !on;
      it++;
      if (rst) begin
        rst = 1'b0; gold_valid = 1'b0;
        void'(sb.pop_back());
        return;
      end
      if (xfer) i++;
      if (!rd) break;
    end
    gold_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    total += 8;
    if (n != e.cycles) begin bad++; $display("FAIL stall_cycles: got %0d want %0d", n, e.cycles); end
    if (stall !== e.stall) begin bad++; $display("FAIL stall_after: got %b want %b", stall, e.stall); end
    if (steps !== e.steps) begin bad++; $display("FAIL step_count: got %0d want %0d", steps, e.steps); end
    if (mis !== e.mis) begin bad++; $display("FAIL mismatch: got %b want %b", mis, e.mis); end
    if (estep !== e.estep) begin bad++; $display("FAIL err_step: got %0d want %0d", estep, e.estep); end
    if (eidx !== e.eidx) begin bad++; $display("FAIL err_index: got %0d want %0d", eidx, e.eidx); end
    if (eexp !== e.eexp) begin bad++; $display("FAIL err_expected: got %h want %h", eexp, e.eexp); end
    if (eact !== e.eact) begin bad++; $display("FAIL err_actual: got %h want %h", eact, e.eact); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 2;
    if ({ready_a, stall_a, mis_a, perr_a, raddr_a} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {ready_a, stall_a, mis_a, perr_a, raddr_a});
    end
    if ({estep_a, eidx_a, eexp_a, eact_a, steps_a} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {estep_a, eidx_a, eexp_a, eact_a, steps_a});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_match();
    sel = 1'b0;
    for (int r = 0; r < 32; r++) cpu_regs[r] = '0;
    cpu_regs[1] = 32'd5;
    cpu_pc = 32'h0040_0004;
    cpu_instr = 32'h2401_0005;
    build_gold();
    run_record(1'b0, -1, -1);
    total++;
    if (steps_a !== 32'd1) begin bad++; $display("FAIL match_steps: got %0d want 1", steps_a); end
  endtask

  task automatic test_bubble();
    rand_state(32'h0040_0008);
    build_gold();
    run_record(1'b1, -1, -1);
  endtask

  task automatic test_proto();
    total++;
    if (perr_a !== 1'b0) begin bad++; $display("FAIL proto_before: got %b want 0", perr_a); end
    rand_state(32'h0040_000c);
    build_gold();
    run_record(1'b0, 10, -1);
    total++;
    if (perr_a !== 1'b1) begin bad++; $display("FAIL proto_err: got %b want 1", perr_a); end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      rand_state(32'h0040_0010 + 32'(4 * s));
      build_gold();
      run_record(1'b0, -1, -1);
    end
  endtask

  task automatic test_reset_mid();
    rand_state(32'h0040_0100);
    build_gold();
    run_record(1'b0, -1, 17);
    model_reset();
    @(negedge clk);
    total += 2;
    if ({ready_a, stall_a, mis_a, perr_a, raddr_a} !== '0) begin
      bad++; $display("FAIL midreset_ctrl: got %b want 0", {ready_a, stall_a, mis_a, perr_a, raddr_a});
    end
    if ({estep_a, eidx_a, eexp_a, eact_a, steps_a} !== '0) begin
      bad++; $display("FAIL midreset_data: got %h want 0", {estep_a, eidx_a, eexp_a, eact_a, steps_a});
    end
    @(posedge clk);
    #1;
    build_gold();
    run_record(1'b0, -1, -1);
    total++;
    if (steps_a !== 32'd1) begin bad++; $display("FAIL midreset_steps: got %0d want 1", steps_a); end
  endtask

  task automatic test_mismatch_halt();
    bit held = 1'b1;
    do_reset();
    sel = 1'b0;
    rand_state(32'h0040_0200);
    cpu_regs[3] = 32'h6;
    build_gold();
    gw[5] = 32'h7;
    run_record(1'b0, -1, -1);
    gold_valid = 1'b1;
    step_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready_a !== 1'b0 || stall_a !== 1'b1) held = 1'b0;
      @(posedge clk);
      #1 step_valid = 1'b0;
    end
    gold_valid = 1'b0;
    total += 3;
    if (!held) begin bad++; $display("FAIL halt_hold: got ready=%b stall=%b want 0/1", ready_a, stall_a); end
    if (eidx_a !== 6'd5 || eexp_a !== 32'h7 || eact_a !== 32'h6) begin
      bad++; $display("FAIL halt_err: got idx=%0d exp=%h act=%h want 5/7/6", eidx_a, eexp_a, eact_a);
    end
    if (perr_a !== 1'b1) begin bad++; $display("FAIL halt_proto: got %b want 1", perr_a); end
  endtask

  task automatic test_no_stop();
    do_reset();
    sel = 1'b1;
    for (int s = 0; s < 5; s++) begin
      rand_state(32'h0040_0300 + 32'(4 * s));
      build_gold();
      if (s == 2) gw[0] = gw[0] ^ 32'h10;
      if (s == 4) gw[33] = gw[33] ^ 32'h1;
      run_record(1'b0, -1, -1);
    end
    total += 3;
    if (estep_b !== 32'd2 || eidx_b !== 6'd0) begin
      bad++; $display("FAIL nostop_err: got step=%0d idx=%0d want 2/0", estep_b, eidx_b);
    end
    if (steps_b !== 32'd5) begin bad++; $display("FAIL nostop_steps: got %0d want 5", steps_b); end
    if (stall_b !== 1'b0) begin bad++; $display("FAIL nostop_stall: got %b want 0", stall_b); end
    sel = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) cpu_regs[r] = '0;
    model_reset();
    test_reset();
    test_match();
    test_bubble();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    test_mismatch_halt();
    test_no_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
